lsu_store_drain: RTL
====================

# lsu_store_drain

Read-side engine for the LSU store FIFO. It pops committed store entries from the FIFO head, one at a time, and presents each to the data-cache write port with a valid/ready request handshake. It then waits for the cache's write acknowledge before issuing the next store. It sits between the store FIFO's read port and the D-cache write interface, and provides an idle indication that the barrier (dbar) logic uses.

## Interface
Parameters
- FIFOWIDE, 68: entry width, packed as {Addr[67:36], Wdata[35:4], Wstrb[3:0]}.
- CNTWIDE, 32: width of the completed-store counter.

Ports
- Clk  in  1  clock; all state is updated on the rising edge.
- Rest  in  1  reset, synchronous, active-low.
- FifoEmpty  in  1  FIFO holds no entries.
- FifoPreOut  in  FIFOWIDE  current FIFO head entry, combinational from the FIFO.
- FifoRable  out  1  one-cycle pop strobe; the FIFO advances its read pointer at the next edge.
- Flush  in  1  same-cycle copy of the FIFO clean strobe.
- StoreValid  out  1  store request valid.
- StoreReady  in  1  cache accepts the request.
- StoreAddr  out  32  byte address of the request.
- StoreData  out  32  write data.
- StoreStrb  out  4  byte enables.
- StoreAck  in  1  one-cycle write-complete pulse from the cache.
- DrainIdle  out  1  FSM is in IDLE and FifoEmpty is high.
- AckErr  out  1  sticky error: StoreAck arrived outside WAIT_ACK.
- StoreCnt  out  CNTWIDE  number of completed stores; wraps modulo 2^CNTWIDE.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK.
- IDLE:
  - If !FifoEmpty and !Flush: assert FifoRable combinationally, latch FifoPreOut into the payload register, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - StoreValid = 1 and the payload is driven from the register.
  - If StoreReady: go to WAIT_ACK.
  - If Flush and !StoreReady in the same cycle: drop the payload and go to IDLE; no store is issued.
  - If Flush and StoreReady in the same cycle: the handshake wins; go to WAIT_ACK.
- WAIT_ACK:
  - StoreValid = 0.
  - On StoreAck: increment StoreCnt.
    - If !FifoEmpty and !Flush: pop and latch the next entry in the same cycle, go to REQ (back-to-back).
    - Otherwise go to IDLE.
  - Flush does not abort WAIT_ACK; the accepted store always completes.
- FifoRable is asserted only in the IDLE or WAIT_ACK-with-ack cases above. It is never asserted while FifoEmpty = 1 or Flush = 1.
- StoreAck seen in IDLE or REQ: set AckErr, which stays set until reset. The FSM ignores the pulse and StoreCnt does not change.
- At most one store is outstanding, so cache writes are strictly ordered by FIFO order.
- Payload fields come directly from the entry slices: Addr = bits 67:36, Wdata = bits 35:4, Wstrb = bits 3:0. No alignment check is performed.

## Timing
- Reset (Rest low at an edge):
  - state = IDLE; payload, StoreCnt and AckErr = 0.
  - Combinational outputs while in reset state: StoreValid = 0, FifoRable = 0.
  - DrainIdle = FifoEmpty.
- Reset mid-transaction discards any captured or outstanding store. A StoreAck arriving after reset for that store sets AckErr.
- Pop-to-request latency: FifoEmpty falls in cycle N while IDLE → FifoRable high in N → StoreValid high in N+1.
- Payload stability: StoreAddr/StoreData/StoreStrb stay unchanged while StoreValid = 1 and StoreReady = 0.
- Ready in REQ cycle R → WAIT_ACK from R+1. StoreAck is accepted no earlier than R+1.
- Ack in cycle M → StoreCnt updated at M+1. If back-to-back, the next StoreValid is high at M+1.
- Sustained throughput is one store per (1 + cache ack latency) cycles.
- DrainIdle is combinational. It is low in any cycle where FifoRable is high.

## Structure
- Shared LSU package holds:
  - entry field offsets and widths (ADDR_LSB = 36, DATA_LSB = 4, STRB_W = 4);
  - the FSM state encoding (2-bit: IDLE = 0, REQ = 1, WAIT_ACK = 2);
  - the default FIFOWIDE.
- No sub-module is needed: one FSM, one payload register, one counter, one sticky flag.
- The block is instantiated next to the store FIFO inside the LSU.

## Test plan
- Single store: push {0x0000_1000, 0xDEAD_BEEF, 0xF}, ready tied high, ack 3 cycles after the handshake → exactly one request with those values; StoreCnt = 1; DrainIdle returns high.
- Back-to-back: 4 entries queued, ack one cycle after each handshake → 4 in-order requests, StoreValid high on the cycle after each ack, StoreCnt = 4, exactly 4 FifoRable pulses.
- Backpressure: StoreReady low for 5 cycles in REQ → payload constant across all 5 cycles, no extra pop, handshake on cycle 6.
- Flush in REQ with ready low → no handshake and state IDLE next cycle; flush in WAIT_ACK → waits for ack, StoreCnt increments, no pop.
- Spurious ack in IDLE → AckErr = 1 and stays 1; StoreCnt unchanged.
- Reset asserted in WAIT_ACK → all outputs at reset values next cycle; a subsequent entry drains normally.

Source files
------------

// File: rtl/lsu_store_drain_pkg.sv
// Shared LSU definitions for the store-drain engine: store FIFO entry layout,
// drain FSM encoding and the default entry width.
package lsu_store_drain_pkg;

   localparam int unsigned FIFOWIDE_DEF = 68;
   localparam int unsigned ADDR_LSB     = 36;
   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_LSB     = 4;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned STRB_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_ACK = 2'd2
   } drain_state_t;

endpackage

// File: rtl/lsu_store_drain.sv
// Store FIFO read-side engine: pops committed stores one at a time and issues
// them to the D-cache write port, waiting for each write acknowledge.
module lsu_store_drain
   import lsu_store_drain_pkg::*;
#(
   parameter int unsigned FIFOWIDE = FIFOWIDE_DEF,
   parameter int unsigned CNTWIDE  = 32
) (
   input  logic                Clk,
   input  logic                Rest,
   input  logic                FifoEmpty,
   input  logic [FIFOWIDE-1:0] FifoPreOut,
   output logic                FifoRable,
   input  logic                Flush,
   output logic                StoreValid,
   input  logic                StoreReady,
   output logic [ADDR_W-1:0]   StoreAddr,
   output logic [DATA_W-1:0]   StoreData,
   output logic [STRB_W-1:0]   StoreStrb,
   input  logic                StoreAck,
   output logic                DrainIdle,
   output logic                AckErr,
   output logic [CNTWIDE-1:0]  StoreCnt
);

   drain_state_t        state_q, state_d;
   logic [FIFOWIDE-1:0] payload_q;
   logic                load;
   logic                cnt_inc;

   always_ff @(posedge Clk) begin
      if (!Rest) begin
         state_q   <= ST_IDLE;
         payload_q <= '0;
         StoreCnt  <= '0;
         AckErr    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load)
            payload_q <= FifoPreOut;
         if (cnt_inc)
            StoreCnt <= StoreCnt + CNTWIDE'(1);
         if (StoreAck && (state_q != ST_WAIT_ACK))
            AckErr <= 1'b1;
      end
   end

   // Pops are suppressed while reset is held so no entry is lost to a capture
   // that the reset branch would discard.
   always_comb begin
      state_d    = state_q;
      FifoRable  = 1'b0;
      StoreValid = 1'b0;
      load       = 1'b0;
      cnt_inc    = 1'b0;
      if (Rest) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!FifoEmpty && !Flush) begin
                  FifoRable = 1'b1;
                  load      = 1'b1;
                  state_d   = ST_REQ;
               end
            end
            ST_REQ: begin
               StoreValid = 1'b1;
               if (StoreReady)
                  state_d = ST_WAIT_ACK;
               else if (Flush)
                  state_d = ST_IDLE;
            end
            ST_WAIT_ACK: begin
               if (StoreAck) begin
                  cnt_inc = 1'b1;
                  if (!FifoEmpty && !Flush) begin
                     FifoRable = 1'b1;
                     load      = 1'b1;
                     state_d   = ST_REQ;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign StoreAddr = payload_q[ADDR_LSB +: ADDR_W];
   assign StoreData = payload_q[DATA_LSB +: DATA_W];
   assign StoreStrb = payload_q[0 +: STRB_W];
   assign DrainIdle = (state_q == ST_IDLE) && FifoEmpty;

endmodule
